// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: op encodings and the layout of a
// buffered result entry {result, sel, zero, carry, parity}.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_AND = 2'b01,
      ALU_OR  = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_e;

   // Everything stored next to the result: sel (2) + zero + carry + parity.
   localparam int ENTRY_EXTRA_W = 5;

   function automatic int entry_width(input int data_w);
      return data_w + ENTRY_EXTRA_W;
   endfunction

endpackage

// File: rtl/alu_fifo.sv
// Generic show-ahead FIFO: dout always shows the head entry while not empty.
// Full/empty come from an occupancy counter so the pointers can simply wrap.
module alu_fifo
   import alu_pkg::*;
#(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LVL_W  = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage is deliberately left out of reset; level alone says what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the combinational ALU: flags each result,
// buffers it in a small FIFO and hands it downstream over valid/ready.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic [1:0]               in_sel,
   input  logic [WIDTH-1:0]         in_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result,
   output logic [1:0]               out_sel,
   output logic                     out_zero,
   output logic                     out_carry,
   output logic                     out_parity,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         op_count
);

   localparam int ENTRY_W = entry_width(WIDTH);
   localparam int LVL_W   = $clog2(DEPTH) + 1;

   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [WIDTH:0]     sum;
   logic               carry;
   logic [ENTRY_W-1:0] din;
   logic [ENTRY_W-1:0] dout;
   logic [LVL_W-1:0]   level_next;
   logic [WIDTH-1:0]   head_result;
   logic [1:0]         head_sel;
   logic               head_zero;
   logic               head_carry;
   logic               head_parity;

   assign push      = in_valid && in_ready && !full;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;

   // Carry is the add's overflow past WIDTH bits, meaningful only for ADD.
   assign sum   = {1'b0, in_a} + {1'b0, in_b};
   assign carry = (in_sel == ALU_ADD) && (sum > {1'b0, {WIDTH{1'b1}}});
   assign din   = {in_result, in_sel, (in_result == '0), carry, ^in_result};

   alu_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign {head_result, head_sel, head_zero, head_carry, head_parity} = dout;

   assign out_result = out_valid ? head_result : '0;
   assign out_sel    = out_valid ? head_sel    : '0;
   assign out_zero   = out_valid && head_zero;
   assign out_carry  = out_valid && head_carry;
   assign out_parity = out_valid && head_parity;

   assign level_next = level + LVL_W'(push) - LVL_W'(pop);

   // in_ready is registered from the next occupancy, so a pop while full only
   // reopens the input one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready <= 1'b0;
      end else begin
         in_ready <= (level_next != LVL_W'(DEPTH));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (push && (op_count != '1)) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; a second instance with a
// 3-bit counter shares the same stimulus to exercise op_count saturation.
module tb_alu_result_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [1:0] in_sel;
   logic [3:0] in_result;
   logic       out_ready;

   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_result;
   logic [1:0] out_sel;
   logic       out_zero;
   logic       out_carry;
   logic       out_parity;
   logic [2:0] level;
   logic [7:0] op_count;

   logic       sat_in_ready;
   logic       sat_out_valid;
   logic [3:0] sat_out_result;
   logic [1:0] sat_out_sel;
   logic       sat_out_zero;
   logic       sat_out_carry;
   logic       sat_out_parity;
   logic [2:0] sat_level;
   logic [2:0] sat_op_count;

   int num_checks = 0;
   int num_fails  = 0;

   logic [3:0] exp_res   [20];
   logic       exp_carry [20];

   always #5 clk = ~clk;

   alu_result_stage #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sel     (in_sel),
      .in_result  (in_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_sel    (out_sel),
      .out_zero   (out_zero),
      .out_carry  (out_carry),
      .out_parity (out_parity),
      .level      (level),
      .op_count   (op_count)
   );

   alu_result_stage #(.WIDTH(4), .DEPTH(4), .CNT_W(3)) dut_sat (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (sat_in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sel     (in_sel),
      .in_result  (in_result),
      .out_valid  (sat_out_valid),
      .out_ready  (out_ready),
      .out_result (sat_out_result),
      .out_sel    (sat_out_sel),
      .out_zero   (sat_out_zero),
      .out_carry  (sat_out_carry),
      .out_parity (sat_out_parity),
      .level      (sat_level),
      .op_count   (sat_op_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic [1:0] sel, input logic [3:0] result);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_sel    = sel;
      in_result = result;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_sel = '0; in_result = '0;

      // Power-on reset
      tick(); tick();
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset level", 32'(level), 32'd0);
      checkOutput("reset op_count", 32'(op_count), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("in_ready before first edge", 32'(in_ready), 32'd0);
      tick();
      checkOutput("in_ready after release", 32'(in_ready), 32'd1);

      // Add with carry out
      applyStimulus(4'hF, 4'h1, 2'b00, 4'h0);
      tick();
      in_valid = 1'b0;
      checkOutput("add out_valid", 32'(out_valid), 32'd1);
      checkOutput("add result", 32'(out_result), 32'h0);
      checkOutput("add zero", 32'(out_zero), 32'd1);
      checkOutput("add carry", 32'(out_carry), 32'd1);
      checkOutput("add parity", 32'(out_parity), 32'd0);
      checkOutput("add level", 32'(level), 32'd1);
      checkOutput("add op_count", 32'(op_count), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("drained out_valid", 32'(out_valid), 32'd0);
      checkOutput("drained zero masked", 32'(out_zero), 32'd0);
      checkOutput("drained level", 32'(level), 32'd0);

      // XOR, then AND with odd parity and an overflowing (ignored) sum
      applyStimulus(4'hA, 4'h3, 2'b11, 4'h9);
      tick();
      in_valid = 1'b0;
      checkOutput("xor result", 32'(out_result), 32'h9);
      checkOutput("xor sel", 32'(out_sel), 32'd3);
      checkOutput("xor zero", 32'(out_zero), 32'd0);
      checkOutput("xor carry", 32'(out_carry), 32'd0);
      checkOutput("xor parity", 32'(out_parity), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      applyStimulus(4'hF, 4'h7, 2'b01, 4'h7);
      tick();
      in_valid = 1'b0;
      checkOutput("and result", 32'(out_result), 32'h7);
      checkOutput("and carry", 32'(out_carry), 32'd0);
      checkOutput("and parity", 32'(out_parity), 32'd1);
      checkOutput("and op_count", 32'(op_count), 32'd3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Fill to DEPTH, hold the 5th, then pop one to let it in
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(4'(i), 4'h0, 2'b10, 4'(i));
         tick();
      end
      checkOutput("full in_ready", 32'(in_ready), 32'd0);
      checkOutput("full level", 32'(level), 32'd4);
      applyStimulus(4'h5, 4'h0, 2'b10, 4'h5);
      tick(); tick();
      checkOutput("held level", 32'(level), 32'd4);
      checkOutput("held in_ready", 32'(in_ready), 32'd0);
      checkOutput("held head", 32'(out_result), 32'h1);
      checkOutput("held op_count", 32'(op_count), 32'd7);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("after pop level", 32'(level), 32'd3);
      checkOutput("after pop in_ready", 32'(in_ready), 32'd1);
      checkOutput("after pop head", 32'(out_result), 32'h2);
      tick();
      in_valid = 1'b0;
      checkOutput("5th accepted level", 32'(level), 32'd4);
      checkOutput("op_count after fill", 32'(op_count), 32'd8);
      checkOutput("sat op_count", 32'(sat_op_count), 32'd7);
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         checkOutput("fill order", 32'(out_result), 32'(i));
         tick();
      end
      out_ready = 1'b0;
      checkOutput("fill drained", 32'(out_valid), 32'd0);

      // Streaming: one result per cycle, level steady at 1
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(4'(k), 4'(k * 5), 2'(k), 4'(k * 3 + 1));
         exp_res[k]   = 4'(k * 3 + 1);
         exp_carry[k] = (2'(k) == 2'b00) && ((k % 16) + ((k * 5) % 16) > 15);
         if (k > 0) begin
            checkOutput("stream result", 32'(out_result), 32'(exp_res[k-1]));
            checkOutput("stream carry", 32'(out_carry), 32'(exp_carry[k-1]));
            checkOutput("stream level", 32'(level), 32'd1);
         end
         tick();
      end
      in_valid = 1'b0;
      checkOutput("stream last", 32'(out_result), 32'(exp_res[19]));
      tick();
      out_ready = 1'b0;
      checkOutput("stream drained level", 32'(level), 32'd0);
      checkOutput("stream op_count", 32'(op_count), 32'd28);
      checkOutput("sat op_count holds", 32'(sat_op_count), 32'd7);

      // Reset with two entries queued
      applyStimulus(4'h3, 4'h4, 2'b00, 4'h7);
      tick();
      applyStimulus(4'h1, 4'h2, 2'b10, 4'h3);
      tick();
      in_valid = 1'b0;
      checkOutput("queued level", 32'(level), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst out_result", 32'(out_result), 32'd0);
      checkOutput("midrst level", 32'(level), 32'd0);
      checkOutput("midrst op_count", 32'(op_count), 32'd0);
      checkOutput("midrst sat op_count", 32'(sat_op_count), 32'd0);
      checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midrst in_ready held", 32'(in_ready), 32'd0);
      tick();
      checkOutput("midrst in_ready release", 32'(in_ready), 32'd1);
      checkOutput("midrst still empty", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
